// File: rtl/cpu_sequencer.sv
// Phase and run-control sequencer for the VeriRISC core: drives the 8-phase
// instruction cycle, tracks idle/run/step/halted state and counts retirements.
module cpu_sequencer #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             run_req,
   input  logic             step_req,
   input  logic             stop_req,
   input  logic             halt,
   input  logic             cnt_clr,
   output logic [2:0]       phase,
   output logic             phase_en,
   output logic [1:0]       state,
   output logic             halted,
   output logic [CNT_W-1:0] instr_cnt
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_STEP   = 2'd2,
      S_HALTED = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [2:0]       phase_q, phase_d;
   logic             stop_pend_q, stop_pend_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic active;
   logic boundary;
   logic stop_any;

   assign active   = (state_q == S_RUN) || (state_q == S_STEP);
   assign boundary = active && (phase_q == 3'd7);
   assign stop_any = stop_pend_q | stop_req;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q     <= S_IDLE;
         phase_q     <= '0;
         stop_pend_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         stop_pend_q <= stop_pend_d;
         cnt_q       <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      phase_d     = '0;
      stop_pend_d = 1'b0;
      cnt_d       = cnt_q;

      case (state_q)
         S_IDLE, S_HALTED: begin
            if (stop_req)      state_d = S_IDLE;
            else if (step_req) state_d = S_STEP;
            else if (run_req)  state_d = S_RUN;
         end
         S_RUN: begin
            if (boundary) begin
               if (halt)          state_d = S_HALTED;
               else if (stop_any) state_d = S_IDLE;
            end
         end
         S_STEP: begin
            // A step ends in IDLE unless halted; run_req mid-step promotes to RUN.
            if (boundary)     state_d = halt ? S_HALTED : S_IDLE;
            else if (run_req) state_d = S_RUN;
         end
      endcase

      if (active && !boundary) begin
         phase_d     = phase_q + 3'd1;
         stop_pend_d = stop_any;
      end

      if (cnt_clr)       cnt_d = '0;
      else if (boundary) cnt_d = cnt_q + CNT_W'(1);
   end

   always_comb begin
      phase_en = (state_q == S_RUN) || (state_q == S_STEP);
      halted   = (state_q == S_HALTED);
   end

   assign phase     = phase_q;
   assign state     = state_q;
   assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: stimulus queues expected outputs per
// cycle; a negedge monitor pops and compares them against two DUT widths.
module tb_cpu_sequencer;

   logic        clk = 1'b0;
   logic        rst_ = 1'b0;
   logic        run_req = 1'b0, step_req = 1'b0, stop_req = 1'b0;
   logic        halt = 1'b0, cnt_clr = 1'b0;
   logic [2:0]  phase, phase2;
   logic        phase_en, phase_en2;
   logic [1:0]  state, state2;
   logic        halted, halted2;
   logic [15:0] instr_cnt;
   logic [1:0]  instr_cnt2;

   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, STEP = 2'd2, HLT = 2'd3;

   typedef struct {
      string       name;
      int unsigned cyc;
      logic [1:0]  st;
      logic [2:0]  ph;
      logic [15:0] cnt;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   int unsigned cycle = 0;
   int          n_cmp = 0;
   int          n_fail = 0;

   cpu_sequencer #(.CNT_W(16)) dut (
      .clk(clk), .rst_(rst_), .run_req(run_req), .step_req(step_req),
      .stop_req(stop_req), .halt(halt), .cnt_clr(cnt_clr),
      .phase(phase), .phase_en(phase_en), .state(state), .halted(halted),
      .instr_cnt(instr_cnt)
   );

   cpu_sequencer #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_(rst_), .run_req(run_req), .step_req(step_req),
      .stop_req(stop_req), .halt(halt), .cnt_clr(cnt_clr),
      .phase(phase2), .phase_en(phase_en2), .state(state2), .halted(halted2),
      .instr_cnt(instr_cnt2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic cmp(input string nm, input string fld, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s: got %0h expected %0h (cycle %0d)", nm, fld, act, exp, cycle);
      end
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cycle) begin
         e = sb.pop_front();
         if (e.cyc != cycle) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s.stale: checked at cycle %0d expected cycle %0d", e.name, cycle, e.cyc);
         end else begin
            cmp(e.name, "state",     16'(state),      16'(e.st));
            cmp(e.name, "phase",     16'(phase),      16'(e.ph));
            cmp(e.name, "phase_en",  16'(phase_en),   16'(e.st == RUN || e.st == STEP));
            cmp(e.name, "halted",    16'(halted),     16'(e.st == HLT));
            cmp(e.name, "instr_cnt", instr_cnt,       e.cnt);
            cmp(e.name, "cnt_w2",    16'(instr_cnt2), 16'(e.cnt[1:0]));
            cmp(e.name, "state_w2",  16'(state2),     16'(e.st));
         end
      end
   end

   task automatic tick(input logic r, input logic s, input logic sp, input logic h, input logic c);
      run_req = r; step_req = s; stop_req = sp; halt = h; cnt_clr = c;
      @(posedge clk);
      #2;
      run_req = 1'b0; step_req = 1'b0; stop_req = 1'b0; halt = 1'b0; cnt_clr = 1'b0;
   endtask

   task automatic idle();
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic expect_st(input string nm, input logic [1:0] st, input logic [2:0] ph, input logic [15:0] cnt);
      exp_t x;
      x.name = nm; x.cyc = cycle; x.st = st; x.ph = ph; x.cnt = cnt;
      sb.push_back(x);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      idle();
      expect_st("reset", IDLE, 3'd0, 16'd0);
      rst_ = 1'b1;
      idle();
      expect_st("idle_after_reset", IDLE, 3'd0, 16'd0);

      // Free run: three instructions.
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_st("run_start", RUN, 3'd0, 16'd0);
      for (int i = 1; i <= 24; i++) begin
         idle();
         expect_st("run_seq", RUN, 3'(i % 8), 16'(i / 8));
      end

      // stop_req at phase 2 completes the instruction, then IDLE.
      idle(); idle();
      expect_st("pre_stop", RUN, 3'd2, 16'd3);
      tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_st("stop_req", RUN, 3'd3, 16'd3);
      for (int i = 4; i <= 7; i++) begin
         idle();
         expect_st("stop_drain", RUN, 3'(i), 16'd3);
      end
      idle();
      expect_st("stop_boundary", IDLE, 3'd0, 16'd4);
      idle();
      expect_st("stop_hold", IDLE, 3'd0, 16'd4);

      // Single step with a redundant step_req mid-instruction.
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_st("step_start", STEP, 3'd0, 16'd4);
      for (int i = 1; i <= 7; i++) begin
         tick(1'b0, i == 3, 1'b0, 1'b0, 1'b0);
         expect_st("step_seq", STEP, 3'(i), 16'd4);
      end
      idle();
      expect_st("step_end", IDLE, 3'd0, 16'd5);
      idle();
      expect_st("step_hold", IDLE, 3'd0, 16'd5);

      // Halt raised from phase 4 of instruction 3.
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_st("clr_idle", IDLE, 3'd0, 16'd0);
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_st("run2_start", RUN, 3'd0, 16'd0);
      for (int i = 1; i <= 24; i++) begin
         tick(1'b0, 1'b0, 1'b0, i >= 21, 1'b0);
         if (i < 24) expect_st("halt_seq", RUN, 3'(i % 8), 16'(i / 8));
         else        expect_st("halt_boundary", HLT, 3'd0, 16'd3);
      end
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      expect_st("halted_hold", HLT, 3'd0, 16'd3);
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_st("resume", RUN, 3'd0, 16'd3);
      idle();
      expect_st("resume_ph1", RUN, 3'd1, 16'd3);
      for (int i = 2; i <= 7; i++) begin
         idle();
         expect_st("resume_seq", RUN, 3'(i), 16'd3);
      end
      tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      expect_st("stop_and_halt", HLT, 3'd0, 16'd4);

      // HALTED: step beats run; run_req mid-step promotes to RUN.
      tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_st("halted_step_run", STEP, 3'd0, 16'd4);
      for (int i = 1; i <= 5; i++) begin
         idle();
         expect_st("step2_seq", STEP, 3'(i), 16'd4);
      end
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_st("step_to_run", RUN, 3'd6, 16'd4);
      idle();
      expect_st("promoted_ph7", RUN, 3'd7, 16'd4);
      idle();
      expect_st("promoted_boundary", RUN, 3'd0, 16'd5);
      idle();
      expect_st("promoted_cont", RUN, 3'd1, 16'd5);
      tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_st("stop2", RUN, 3'd2, 16'd5);
      for (int i = 3; i <= 7; i++) begin
         idle();
         expect_st("stop2_drain", RUN, 3'(i), 16'd5);
      end
      idle();
      expect_st("stop2_boundary", IDLE, 3'd0, 16'd6);

      // All three requests in IDLE: stop wins.
      tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      expect_st("idle_all_req", IDLE, 3'd0, 16'd6);

      // cnt_clr coincident with a boundary increment.
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_st("run3_start", RUN, 3'd0, 16'd6);
      for (int i = 1; i <= 7; i++) begin
         idle();
         expect_st("run3_seq", RUN, 3'(i), 16'd6);
      end
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_st("clr_at_boundary", RUN, 3'd0, 16'd0);

      // Asynchronous reset pulse entirely between clock edges at phase 5.
      for (int i = 1; i <= 13; i++) begin
         idle();
         expect_st("run4_seq", RUN, 3'(i % 8), 16'(i / 8));
      end
      @(negedge clk);
      #1 rst_ = 1'b0;
      #2 rst_ = 1'b1;
      idle();
      expect_st("async_reset", IDLE, 3'd0, 16'd0);
      idle();
      expect_st("post_reset_hold", IDLE, 3'd0, 16'd0);

      repeat (2) @(negedge clk);
      #1;
      cmp("scoreboard", "drained", 16'(sb.size()), 16'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
